// File: rtl/truth_table_scanner_if.sv
// -----------------------------------------------------------------------------
// truth_table_scanner_if
//   Groups the request handshake, the drive/capture path to the function under
//   test, and the result bus of truth_table_scanner into one bundle.
//
//   Signals (direction as seen by the scanner, i.e. the slave modport):
//     start         in   1          scan request, honoured in IDLE only
//     dut_in        out  N_IN       input code presented to the function
//     dut_out       in   1          function output for the current dut_in
//     busy          out  1          scan in progress
//     done          out  1          one-cycle pulse, results valid
//     minterm_mask  out  2**N_IN    bit k = function value at input code k
//     minterm_cnt   out  N_IN+1     number of ones in minterm_mask
//     match         out  1          minterm_mask equals the expected mask
//
//   master : requester / harness side (drives start and dut_out)
//   slave  : scanner side
// -----------------------------------------------------------------------------
interface truth_table_scanner_if #(
  parameter int N_IN = 3
);
  logic                 start;
  logic [N_IN-1:0]      dut_in;
  logic                 dut_out;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   minterm_mask;
  logic [N_IN:0]        minterm_cnt;
  logic                 match;

  modport master (
    output start,
    output dut_out,
    input  dut_in,
    input  busy,
    input  done,
    input  minterm_mask,
    input  minterm_cnt,
    input  match
  );

  modport slave (
    input  start,
    input  dut_out,
    output dut_in,
    output busy,
    output done,
    output minterm_mask,
    output minterm_cnt,
    output match
  );
endinterface

// File: rtl/truth_table_scanner.sv
// -----------------------------------------------------------------------------
// truth_table_scanner
//   Reads back an N_IN-input, 1-output combinational Boolean function. On each
//   accepted start it walks every input code 0 .. 2**N_IN-1, holds each code
//   for SETTLE_CYCLES cycles so the function can settle, then samples the
//   function output into a minterm mask and a running minterm count.
//
//   Optional feature macro: EXPECT_CHECK_EN
//     defined   : match is set on the edge entering DONE when the final mask
//                 equals EXPECT_MASK; cleared on start and reset.
//     undefined : match is tied low and no comparator is built.
//
//   Ports
//     clk   in   rising-edge clock
//     rst   in   asynchronous, active-high reset (released synchronously by
//                the surrounding reset tree)
//     bus   slave modport of truth_table_scanner_if:
//             start, dut_out (in); dut_in, busy, done, minterm_mask,
//             minterm_cnt, match (out). All outputs are registered.
//
//   Timing: each code costs SETTLE_CYCLES+1 edges (SETTLE_CYCLES in DRIVE,
//   one in SAMPLE), so done rises 2**N_IN*(SETTLE_CYCLES+1) edges after the
//   edge that accepted start.
// -----------------------------------------------------------------------------
module truth_table_scanner #(
  parameter int                 N_IN          = 3,
  parameter int                 SETTLE_CYCLES = 1,
  parameter logic [2**N_IN-1:0] EXPECT_MASK   = 8'h75
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_scanner_if.slave  bus
);

  localparam int MW = 2**N_IN;
  localparam int CW = N_IN + 1;
  // Settle counter counts 0 .. SETTLE_CYCLES-1; keep at least one bit.
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [N_IN-1:0] IDX_ZERO    = {N_IN{1'b0}};
  localparam logic [N_IN-1:0] IDX_ONE     = N_IN'(1'b1);
  localparam logic [N_IN-1:0] IDX_LAST    = {N_IN{1'b1}};
  localparam logic [SW-1:0]   SETTLE_ZERO = {SW{1'b0}};
  localparam logic [SW-1:0]   SETTLE_ONE  = SW'(1'b1);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0]   MASK_ZERO   = {MW{1'b0}};
  localparam logic [CW-1:0]   CNT_ZERO    = {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Registered state and outputs.
  state_t          state_r;
  logic [N_IN-1:0] idx_r;      // current code; doubles as the dut_in driver
  logic [SW-1:0]   settle_r;
  logic            busy_r;
  logic            done_r;
  logic [MW-1:0]   mask_r;
  logic [CW-1:0]   cnt_r;
  logic            match_r;

  // Next-state values.
  state_t          state_s;
  logic [N_IN-1:0] idx_s;
  logic [SW-1:0]   settle_s;
  logic            busy_s;
  logic            done_s;
  logic [MW-1:0]   mask_s;
  logic [CW-1:0]   cnt_s;
  logic            match_s;

`ifndef EXPECT_CHECK_EN
  // Keeps EXPECT_MASK referenced in builds without the expected-mask check;
  // folds to a constant and drives nothing.
  logic unused_expect_mask;
  assign unused_expect_mask = ^EXPECT_MASK;
`endif

  // Next-state and next-output decode for the scan sequencer.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    settle_s = settle_r;
    busy_s   = busy_r;
    done_s   = 1'b0;      // done is a single-cycle pulse
    mask_s   = mask_r;
    cnt_s    = cnt_r;
    match_s  = match_r;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          // New scan: clear results, present code 0 immediately.
          state_s  = DRIVE;
          idx_s    = IDX_ZERO;
          settle_s = SETTLE_ZERO;
          busy_s   = 1'b1;
          mask_s   = MASK_ZERO;
          cnt_s    = CNT_ZERO;
          match_s  = 1'b0;
        end else begin
          state_s  = IDLE;
        end
      end

      DRIVE: begin
        // Hold the code for SETTLE_CYCLES edges; dut_out is ignored here so
        // settling glitches cannot reach the result.
        if (settle_r == SETTLE_LAST) begin
          state_s  = SAMPLE;
          settle_s = SETTLE_ZERO;
        end else begin
          state_s  = DRIVE;
          settle_s = settle_r + SETTLE_ONE;
        end
      end

      SAMPLE: begin
        mask_s[idx_r] = bus.dut_out;
        cnt_s         = cnt_r + CW'(bus.dut_out);
        if (idx_r == IDX_LAST) begin
          // Last code captured: idx stays at the top code (no wrap).
          state_s = DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
`ifdef EXPECT_CHECK_EN
          // Compare the final mask, including the bit captured on this edge.
          match_s = (mask_s == EXPECT_MASK);
`else
          match_s = 1'b0;
`endif
        end else begin
          state_s = DRIVE;
          idx_s   = idx_r + IDX_ONE;
        end
      end

      DONE: begin
        // Requests seen here are dropped, not queued.
        state_s = IDLE;
      end

      default: begin
        // Unreachable encoding: return to a quiet idle.
        state_s  = IDLE;
        settle_s = SETTLE_ZERO;
        busy_s   = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      idx_r    <= IDX_ZERO;
      settle_r <= SETTLE_ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      mask_r   <= MASK_ZERO;
      cnt_r    <= CNT_ZERO;
      match_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      settle_r <= settle_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      mask_r   <= mask_s;
      cnt_r    <= cnt_s;
      match_r  <= match_s;
    end
  end

  assign bus.dut_in       = idx_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.minterm_mask = mask_r;
  assign bus.minterm_cnt  = cnt_r;
  assign bus.match        = match_r;

endmodule
